// File: rtl/proc_pkg.sv
// Shared types and constants for the 8-bit processor control path.
// Opcode, ALU-function and sequencer-state encodings live here so decode and bench agree.
package proc_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [3:0] {
    OpNop = 4'h0,
    OpAdd = 4'h1,
    OpSub = 4'h2,
    OpAnd = 4'h3,
    OpOr  = 4'h4,
    OpXor = 4'h5,
    OpNot = 4'h6,
    OpMov = 4'h7,
    OpLdi = 4'h8,
    OpJmp = 4'h9,
    OpJz  = 4'hA,
    OpHlt = 4'hF
  } opcode_t;

  typedef enum logic [3:0] {
    AluPass = 4'd0,
    AluAdd  = 4'd1,
    AluSub  = 4'd2,
    AluAnd  = 4'd3,
    AluOr   = 4'd4,
    AluXor  = 4'd5,
    AluNot  = 4'd6
  } alu_op_t;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StWb1,
    StWb2,
    StHalt
  } ctrl_state_t;

  localparam logic [1:0] DI_ALU = 2'd0;
  localparam logic [1:0] DI_IMM = 2'd1;
  localparam logic [1:0] DI_RA  = 2'd2;

  localparam logic [3:0] REG_PIN = 4'd10;

  // Opcodes 1..8 write a result back into the bank.
  function automatic logic is_write_op(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'h8);
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter with load-immediate, increment and hold; synchronous active-high reset.
// Wraps silently at the top of the address space.
module pc_unit
  import proc_pkg::*;
#(
  parameter int unsigned PcW = PC_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc_i,
  input  logic           load_i,
  input  logic [PcW-1:0] load_val_i,
  output logic [PcW-1:0] pc_o
);

  localparam logic [PcW-1:0] PcOne = PcW'(1);

  logic [PcW-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PcOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/bank_seq_ctrl.sv
// Multicycle sequencer for the 16x8 register bank: fetch, decode, execute, two-cycle write-back.
// Sources and Di stay stable across WB1/WB2 because the bank registers its write select.
module bank_seq_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned PC_W    = proc_pkg::PC_W,
  parameter int unsigned INSTR_W = proc_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               alu_zero,
  output logic [3:0]         sba,
  output logic [3:0]         sbb,
  output logic [3:0]         srd,
  output logic               le,
  output logic [3:0]         alu_op,
  output logic [1:0]         di_sel,
  output logic [7:0]         imm,
  output logic               illegal_op,
  output logic               halted
);

  ctrl_state_t        state_d, state_q;
  logic [INSTR_W-1:0] ir_d, ir_q;

  logic [3:0] op, rd, ra, rb;
  logic       wr_op, pin_wr, bad_op;
  logic [3:0] dec_alu;
  logic [1:0] dec_di;
  logic       pc_inc, pc_load;

  assign op = ir_q[15:12];
  assign rd = ir_q[11:8];
  assign ra = ir_q[7:4];
  assign rb = ir_q[3:0];

  assign wr_op  = is_write_op(op);
  assign pin_wr = wr_op && (rd == REG_PIN);
  assign bad_op = (op >= 4'hB) && (op <= 4'hE);

  always_comb begin
    dec_alu = AluPass;
    dec_di  = DI_ALU;
    case (op)
      OpAdd:   dec_alu = AluAdd;
      OpSub:   dec_alu = AluSub;
      OpAnd:   dec_alu = AluAnd;
      OpOr:    dec_alu = AluOr;
      OpXor:   dec_alu = AluXor;
      OpNot:   dec_alu = AluNot;
      OpMov:   dec_di  = DI_RA;
      OpLdi:   dec_di  = DI_IMM;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    sba        = '0;
    sbb        = '0;
    srd        = '0;
    le         = 1'b0;
    alu_op     = '0;
    di_sel     = '0;
    imm        = '0;
    illegal_op = 1'b0;
    halted     = 1'b0;

    // Bank sources are held from EXEC through WB2.
    if (state_q == StExec || state_q == StWb1 || state_q == StWb2) begin
      sba    = ra;
      sbb    = rb;
      alu_op = dec_alu;
      di_sel = dec_di;
      imm    = ir_q[7:0];
    end

    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        ir_d    = instr;
        state_d = StExec;
      end
      StExec: begin
        illegal_op = bad_op || pin_wr;
        if (op == OpHlt) begin
          state_d = StHalt;
        end else if (wr_op && !pin_wr) begin
          state_d = StWb1;
        end else begin
          state_d = StFetch;
          if (op == OpJmp || (op == OpJz && alu_zero)) begin
            pc_load = 1'b1;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      StWb1: begin
        le      = 1'b1;
        srd     = rd;
        state_d = StWb2;
      end
      StWb2: begin
        srd     = rd;
        pc_inc  = 1'b1;
        state_d = StFetch;
      end
      StHalt:  halted = 1'b1;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  pc_unit #(
    .PcW(PC_W)
  ) u_pc_unit (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (pc_inc),
    .load_i    (pc_load),
    .load_val_i(PC_W'(ir_q[7:0])),
    .pc_o      (pc)
  );

endmodule

// File: tb/tb_bank_seq_ctrl.sv
// Self-checking bench for bank_seq_ctrl: directed program plus random ROM contents,
// compared cycle by cycle against an instruction-level timing model.
module tb_bank_seq_ctrl;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc;
  logic [15:0] instr = '0;
  logic        alu_zero;
  logic [3:0]  sba, sbb, srd, alu_op;
  logic        le, illegal_op, halted;
  logic [1:0]  di_sel;
  logic [7:0]  imm;

  logic [15:0] rom [256];
  logic [7:0]  mpc;
  int          n_checks = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) instr <= rom[pc];

  bank_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .instr     (instr),
    .alu_zero  (alu_zero),
    .sba       (sba),
    .sbb       (sbb),
    .srd       (srd),
    .le        (le),
    .alu_op    (alu_op),
    .di_sel    (di_sel),
    .imm       (imm),
    .illegal_op(illegal_op),
    .halted    (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h (model pc=%0h)", tag, obs, exp, mpc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Executes the instruction at the model pc, checking every cycle; leaves bench in next FETCH.
  task automatic run_instr(input logic z);
    logic [15:0] w;
    logic [3:0]  op, rd, ra, rb;
    logic [7:0]  im, nxt;
    logic        wr, ill, alu_known;
    logic [3:0]  exp_alu;
    logic [1:0]  exp_di;
    int          n;
    w  = rom[mpc];
    op = w[15:12];
    rd = w[11:8];
    ra = w[7:4];
    rb = w[3:0];
    im = w[7:0];
    wr = (op >= 4'd1) && (op <= 4'd8);
    ill = ((op >= 4'hB) && (op <= 4'hE)) || (wr && rd == 4'd10);
    n = (wr && rd != 4'd10) ? 5 : 3;
    if (op == 4'h9) nxt = im;
    else if (op == 4'hA) nxt = z ? im : mpc + 8'd1;
    else nxt = mpc + 8'd1;
    alu_known = 1'b1;
    exp_alu = AluPass;
    case (op)
      4'h1: exp_alu = AluAdd;
      4'h2: exp_alu = AluSub;
      4'h3: exp_alu = AluAnd;
      4'h4: exp_alu = AluOr;
      4'h5: exp_alu = AluXor;
      4'h6: exp_alu = AluNot;
      4'hA: exp_alu = AluPass;
      default: alu_known = 1'b0;
    endcase
    exp_di = (op == 4'h7) ? 2'd2 : (op == 4'h8) ? 2'd1 : 2'd0;
    alu_zero = z;
    for (int k = 1; k <= n; k++) begin
      chk("pc", pc, mpc);
      chk("le", le, k == 4);
      chk("illegal_op", illegal_op, (k == 3) && ill);
      chk("halted", halted, 0);
      if (k >= 3) begin
        chk("sba", sba, ra);
        chk("sbb", sbb, rb);
        chk("imm", imm, im);
        if (alu_known) chk("alu_op", alu_op, exp_alu);
        if (wr) chk("di_sel", di_sel, exp_di);
      end
      if (k == 4) chk("srd", srd, rd);
      tick();
    end
    mpc = nxt;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h0;
      rom[i] = w;
    end
    rom[8'h00] = 16'h835A;  // LDI r3,0x5A
    rom[8'h01] = 16'h1201;  // ADD r2,r0,r1
    rom[8'h02] = 16'hA420;  // JZ r4,0x20 (taken)
    rom[8'h20] = 16'hA430;  // JZ r4,0x30 (not taken)
    rom[8'h21] = 16'h8A11;  // LDI r10,0x11 -> illegal
    rom[8'h22] = 16'hC123;  // undefined opcode
    rom[8'h23] = 16'h90FF;  // JMP 0xFF
    rom[8'hFF] = 16'h0000;  // NOP, pc wraps

    rst = 1'b1;
    alu_zero = 1'b0;
    repeat (3) tick();
    chk("rst_pc", pc, 0);
    chk("rst_le", le, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_halted", halted, 0);
    chk("rst_sel", {sba, sbb, srd, alu_op, di_sel, imm}, 0);
    rst = 1'b0;
    mpc = 8'h00;

    run_instr(1'b0);
    chk("ldi_next_pc", pc, 8'h01);
    run_instr(1'b0);
    run_instr(1'b1);
    chk("jz_taken_pc", pc, 8'h20);
    run_instr(1'b0);
    chk("jz_fall_pc", pc, 8'h21);
    run_instr(1'b0);
    run_instr(1'b0);
    run_instr(1'b0);
    chk("jmp_pc", pc, 8'hFF);
    run_instr(1'b0);
    chk("wrap_pc", pc, 8'h00);

    repeat (80) run_instr(1'($urandom_range(0, 1)));

    rom[mpc] = 16'hF000;
    chk("hlt_fetch_pc", pc, mpc);
    tick();
    chk("hlt_decode_pc", pc, mpc);
    tick();
    chk("hlt_exec_le", le, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halted", halted, 1);
      chk("halt_pc", pc, mpc);
      chk("halt_le", le, 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("unhalt", halted, 0);
    chk("unhalt_pc", pc, 0);
    mpc = 8'h00;

    tick();
    tick();
    tick();
    chk("wb1_le", le, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wb1_rst_le", le, 0);
    chk("wb1_rst_pc", pc, 0);
    chk("wb1_rst_sel", {sba, sbb, srd, di_sel, imm}, 0);
    mpc = 8'h00;
    run_instr(1'b0);
    run_instr(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
